oram_path_sequencer: RTL

- Sequences one Path ORAM access against the DRAM controller (MIG user interface).
- For an accepted leaf, it reads every bucket on the root-to-leaf path, draining the read FIFO as it goes.
- It then writes the path back, leaf-to-root, pulling eviction beats from the stash side.
- It sits between the PosMap/Stash front end and the MIG, and replaces ad-hoc enable gating of address generation with a real command/data scheduler.

---
 rtl/oram_path_sequencer_pkg.sv | 27 ++
 rtl/oram_path_addr.sv | 46 ++++
 rtl/oram_path_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/oram_path_sequencer_pkg.sv
// Shared definitions for the Path ORAM access sequencer and its helpers.
//   MIG_READ / MIG_WRITE : MIG user-interface instruction codes
//   state_t              : sequencer state encoding
//   BKT_LOG_MAX          : largest log2(bursts per bucket) (BktBurstsLog is 3 bits)
//   beat_cnt_width()     : width of a counter that can hold a full path's beat count
package oram_path_sequencer_pkg;

  localparam logic [2:0] MIG_READ  = 3'b001;
  localparam logic [2:0] MIG_WRITE = 3'b000;

  localparam int BKT_LOG_MAX = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // A path has at most 2^max_log_l buckets, each of at most 2^BKT_LOG_MAX bursts
  // of beats_per_burst beats; one extra bit lets the counter reach the total itself.
  function automatic int beat_cnt_width(input int max_log_l, input int beats_per_burst);
    return max_log_l + BKT_LOG_MAX + $clog2(beats_per_burst) + 1;
  endfunction

endpackage

// File: rtl/oram_path_addr.sv
// Combinational Path ORAM bucket/burst address calculator.
//   leaf    : leaf label (only the low `levels` bits matter)
//   levels  : L, the path spans levels 0..L
//   level   : level v of the bucket being addressed
//   burst   : burst index k inside the bucket
//   bkt_log : log2 of bursts per bucket
//   addr    : ((node << bkt_log) + k) << ADDR_STRIDE_LOG, truncated,
//             with node = (2^v - 1) + low v bits of (leaf >> (L - v))
module oram_path_addr
  import oram_path_sequencer_pkg::*;
#(
  parameter int MAX_ORAM_L      = 32,
  parameter int MAX_LOG_L       = 5,
  parameter int DRAM_ADDR_WIDTH = 30,
  parameter int ADDR_STRIDE_LOG = 3
) (
  input  logic [MAX_ORAM_L-1:0]      leaf,
  input  logic [MAX_LOG_L-1:0]       levels,
  input  logic [MAX_LOG_L-1:0]       level,
  input  logic [BKT_LOG_MAX-1:0]     burst,
  input  logic [2:0]                 bkt_log,
  output logic [DRAM_ADDR_WIDTH-1:0] addr
);

  // Node indices of a heap-ordered tree need one bit more than the leaf label.
  localparam int NW    = MAX_ORAM_L + 1;
  localparam int RAW_W = NW + BKT_LOG_MAX + ADDR_STRIDE_LOG;
  localparam int AW    = (RAW_W > DRAM_ADDR_WIDTH) ? RAW_W : DRAM_ADDR_WIDTH;

  logic [MAX_LOG_L-1:0] shift;
  logic [NW-1:0]        level_base;
  logic [NW-1:0]        path_bits;
  logic [NW-1:0]        node;
  logic [AW-1:0]        bucket_burst;
  logic [AW-1:0]        byte_addr;

  assign shift = levels - level;
  // 2^v - 1 is both the first node of level v and the mask for v path bits.
  assign level_base   = (NW'(1) << level) - NW'(1);
  assign path_bits    = (NW'(leaf) >> shift) & level_base;
  assign node         = level_base + path_bits;
  assign bucket_burst = (AW'(node) << bkt_log) + AW'(burst);
  assign byte_addr    = bucket_burst << ADDR_STRIDE_LOG;
  assign addr         = byte_addr[DRAM_ADDR_WIDTH-1:0];

endmodule

// File: rtl/oram_path_sequencer.sv
// Path ORAM access sequencer in front of a MIG user interface.
// Reads every bucket root-to-leaf while draining the read FIFO, then writes
// the path back leaf-to-root, pulling beats from the stash before issuing
// each write command.
//   Clock, Reset                   : clock, asynchronous active-high reset
//   StartValid/StartReady          : leaf request handshake (StartLeaf, ORAMLevels,
//                                    BktBurstsLog sampled on acceptance)
//   MIGRdy/MIGEn/MIGInstr/MIGAddr  : MIG command channel
//   RdEmpty/RdEn                   : read-data FIFO pop
//   WrSrcValid/WrFull/WrEn/WrDataEnd : write-data push (WrEn is the stash ready)
//   PathDone                       : one-cycle pulse when write-back finishes
//   Busy                           : high whenever not idle
module oram_path_sequencer
  import oram_path_sequencer_pkg::*;
#(
  parameter int MAX_ORAM_L      = 32,
  parameter int MAX_LOG_L       = 5,
  parameter int DRAM_ADDR_WIDTH = 30,
  parameter int BEATS_PER_BURST = 2,
  parameter int ADDR_STRIDE_LOG = 3
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       StartValid,
  output logic                       StartReady,
  input  logic [MAX_ORAM_L-1:0]      StartLeaf,
  input  logic [MAX_LOG_L-1:0]       ORAMLevels,
  input  logic [2:0]                 BktBurstsLog,
  input  logic                       MIGRdy,
  output logic                       MIGEn,
  output logic [2:0]                 MIGInstr,
  output logic [DRAM_ADDR_WIDTH-1:0] MIGAddr,
  input  logic                       RdEmpty,
  output logic                       RdEn,
  input  logic                       WrSrcValid,
  input  logic                       WrFull,
  output logic                       WrEn,
  output logic                       WrDataEnd,
  output logic                       PathDone,
  output logic                       Busy
);

  localparam int              BCW      = beat_cnt_width(MAX_LOG_L, BEATS_PER_BURST);
  localparam int              BPB_LOG  = $clog2(BEATS_PER_BURST);
  localparam logic [BCW-1:0]  BPB_MASK = BCW'(BEATS_PER_BURST - 1);
  localparam logic [BCW-1:0]  BCW_ONE  = BCW'(1);

  state_t state_reg, state_next;

  logic [MAX_ORAM_L-1:0]      leaf_reg;
  logic [MAX_LOG_L-1:0]       levels_reg;
  logic [MAX_LOG_L-1:0]       level_reg;
  logic [2:0]                 bkt_log_reg;
  logic [BKT_LOG_MAX-1:0]     burst_reg;
  logic [BCW-1:0]             rd_beats_reg;
  logic [BCW-1:0]             wr_beats_reg;
  logic [BCW-1:0]             wr_cmds_reg;

  logic [BCW-1:0]             total_beats;
  logic [BCW-1:0]             wr_bursts;
  logic [BKT_LOG_MAX-1:0]     last_burst;
  logic                       burst_wrap;
  logic                       rd_pop_ok;
  logic                       wr_push_ok;
  logic                       wr_cmd_ok;
  logic                       cmd_accept;
  logic [DRAM_ADDR_WIDTH-1:0] path_addr;

  // Beats on the whole path: (L+1) buckets * 2^bkt_log bursts * beats per burst.
  assign total_beats = ((BCW'(levels_reg) + BCW_ONE) << bkt_log_reg) << BPB_LOG;
  assign last_burst  = BKT_LOG_MAX'((8'd1 << bkt_log_reg) - 8'd1);
  assign burst_wrap  = (burst_reg == last_burst);

  assign rd_pop_ok  = ~RdEmpty && (rd_beats_reg < total_beats);
  assign wr_push_ok = WrSrcValid && ~WrFull && (wr_beats_reg < total_beats);
  // A write command may only go out once its whole burst sits in the write FIFO.
  assign wr_bursts  = wr_beats_reg >> BPB_LOG;
  assign wr_cmd_ok  = (wr_bursts > wr_cmds_reg);
  assign cmd_accept = MIGEn && MIGRdy;

  oram_path_addr #(
    .MAX_ORAM_L     (MAX_ORAM_L),
    .MAX_LOG_L      (MAX_LOG_L),
    .DRAM_ADDR_WIDTH(DRAM_ADDR_WIDTH),
    .ADDR_STRIDE_LOG(ADDR_STRIDE_LOG)
  ) u_addr (
    .leaf   (leaf_reg),
    .levels (levels_reg),
    .level  (level_reg),
    .burst  (burst_reg),
    .bkt_log(bkt_log_reg),
    .addr   (path_addr)
  );

  // Address is zero whenever no command is offered, so idle/reset outputs are all 0.
  assign MIGAddr = MIGEn ? path_addr : '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    StartReady = 1'b0;
    Busy       = 1'b1;
    MIGEn      = 1'b0;
    MIGInstr   = MIG_WRITE;
    RdEn       = 1'b0;
    WrEn       = 1'b0;
    WrDataEnd  = 1'b0;
    PathDone   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        StartReady = 1'b1;
        Busy       = 1'b0;
        if (StartValid) state_next = S_READ;
      end
      S_READ: begin
        MIGEn    = 1'b1;
        MIGInstr = MIG_READ;
        RdEn     = rd_pop_ok;
        if (MIGRdy && burst_wrap && (level_reg == levels_reg)) state_next = S_RD_DRAIN;
      end
      S_RD_DRAIN: begin
        RdEn = rd_pop_ok;
        if (rd_beats_reg == total_beats) state_next = S_WRITE;
      end
      S_WRITE: begin
        WrEn      = wr_push_ok;
        WrDataEnd = wr_push_ok && ((wr_beats_reg & BPB_MASK) == BPB_MASK);
        MIGEn     = wr_cmd_ok;
        if (wr_cmd_ok && MIGRdy && burst_wrap && (level_reg == '0)) state_next = S_DONE;
      end
      S_DONE: begin
        PathDone   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        Busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      leaf_reg     <= '0;
      levels_reg   <= '0;
      level_reg    <= '0;
      bkt_log_reg  <= '0;
      burst_reg    <= '0;
      rd_beats_reg <= '0;
      wr_beats_reg <= '0;
      wr_cmds_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (StartValid) begin
            leaf_reg     <= StartLeaf;
            levels_reg   <= ORAMLevels;
            bkt_log_reg  <= BktBurstsLog;
            level_reg    <= '0;
            burst_reg    <= '0;
            rd_beats_reg <= '0;
            wr_beats_reg <= '0;
            wr_cmds_reg  <= '0;
          end
        end
        S_READ: begin
          if (cmd_accept) begin
            if (burst_wrap) begin
              burst_reg <= '0;
              // The last level is held so the drain/write hand-off sees a stable count.
              if (level_reg != levels_reg) level_reg <= level_reg + MAX_LOG_L'(1);
            end else begin
              burst_reg <= burst_reg + BKT_LOG_MAX'(1);
            end
          end
          if (RdEn) rd_beats_reg <= rd_beats_reg + BCW_ONE;
        end
        S_RD_DRAIN: begin
          if (RdEn) rd_beats_reg <= rd_beats_reg + BCW_ONE;
          if (state_next == S_WRITE) begin
            level_reg <= levels_reg;
            burst_reg <= '0;
          end
        end
        S_WRITE: begin
          if (WrEn) wr_beats_reg <= wr_beats_reg + BCW_ONE;
          if (cmd_accept) begin
            wr_cmds_reg <= wr_cmds_reg + BCW_ONE;
            if (burst_wrap) begin
              burst_reg <= '0;
              if (level_reg != '0) level_reg <= level_reg - MAX_LOG_L'(1);
            end else begin
              burst_reg <= burst_reg + BKT_LOG_MAX'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
